// File: rtl/game_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// game_ctrl_pkg
//  Shared types for the zero-stopwatch game sequencer.
//   msg_t         : message select driven into the 7-segment message mux
//   game_state_t  : round sequencer states
//   WIN_COUNT_MAX : saturation value of the win counter
//   sat_inc8      : saturating 8-bit increment used by the win counter
// ----------------------------------------------------------------------------
package game_ctrl_pkg;

   typedef enum logic [2:0] {
      EMPTY_MSG     = 3'd0,
      WELCOME_MSG   = 3'd1,
      READY_MSG     = 3'd2,
      STOPWATCH_MSG = 3'd3,
      WIN_MSG       = 3'd4
   } msg_t;

   typedef enum logic [2:0] {
      WELCOME = 3'd0,
      READY   = 3'd1,
      RUN     = 3'd2,
      CHECK   = 3'd3,
      WIN     = 3'd4,
      LOSE    = 3'd5,
      FOUL    = 3'd6
   } game_state_t;

   localparam logic [7:0] WIN_COUNT_MAX = 8'd255;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == WIN_COUNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/game_ctrl_tick.sv
// ----------------------------------------------------------------------------
// tick_timer
//  Down-counter measured in tick strobes. A load (which wins over a tick in
//  the same cycle) arms it with value_i, a value of 0 being taken as 1.
//  expired_o is high on the tick that takes the count from 1 to 0, so an
//  armed timer expires on exactly the value_i-th tick after the load.
// Ports
//  clk_i, rst_ni   clock, asynchronous active-low reset
//  load_i          arm the counter with value_i
//  value_i [W]     tick count to arm with
//  tick_i          tick strobe
//  expired_o       combinational expiry strobe (tick_i with count == 1)
// ----------------------------------------------------------------------------
module tick_timer #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   input  logic         tick_i,
   output logic         expired_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q, cnt_d;

   // next count: load wins, otherwise count ticks down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = (value_i == '0) ? ONE : value_i;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign expired_o = tick_i && (cnt_q == ONE);

endmodule

// File: rtl/game_ctrl.sv
// ----------------------------------------------------------------------------
// game_ctrl
//  Round sequencer for the zero-stopwatch game:
//  WELCOME -> READY countdown -> RUN stopwatch -> CHECK -> WIN/LOSE, or FOUL
//  on an early stop. All outputs are registered; msg_o and sw_run_o are
//  derived from the current state and so lag a transition by one clock.
// Ports
//  clk_i, rst_ni   clock, asynchronous active-low reset
//  tick_i          1 kHz single-cycle strobe
//  start_i/stop_i  debounced button pulses
//  sw_frac_i [7]   stopwatch hundredths, binary 0..99
//  sw_ovf_i        stopwatch overflow level
//  msg_o           message select for the 7-seg mux
//  sw_run_o        stopwatch count enable
//  sw_clear_o      one-cycle stopwatch clear on READY entry
//  win_o           one-cycle pulse on each win
//  win_count_o [8] saturating win counter
// Configuration
//  GAME_CTRL_BLINK_EN : WIN message blinks WIN_MSG/EMPTY_MSG, BLINK_TICKS
//                       per phase, starting on WIN_MSG. Undefined: steady.
// ----------------------------------------------------------------------------
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int READY_TICKS  = 1500,
   parameter int RESULT_TICKS = 3000,
   parameter int BLINK_TICKS  = 250,
   parameter int TIMER_W      = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic [6:0] sw_frac_i,
   input  logic       sw_ovf_i,
   output msg_t       msg_o,
   output logic       sw_run_o,
   output logic       sw_clear_o,
   output logic       win_o,
   output logic [7:0] win_count_o
);

   game_state_t        state_q, state_d;
   msg_t               msg_q, msg_d, win_msg;
   logic               run_q, run_d, clear_q, clear_d, win_q, win_d;
   logic [7:0]         count_q, count_d;
   logic               entering, tmr_exp;
   logic [TIMER_W-1:0] tmr_value;

   assign entering = (state_d != state_q);

   // round / ready timer, armed on every state entry
   tick_timer #(.W(TIMER_W)) u_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (entering),
      .value_i   (tmr_value),
      .tick_i    (tick_i),
      .expired_o (tmr_exp)
   );

`ifdef GAME_CTRL_BLINK_EN
   logic blink_q, blink_d, blink_load, blink_exp;

   // rearm on WIN entry and at the end of every blink phase
   assign blink_load = (entering && (state_d == WIN)) || blink_exp;

   tick_timer #(.W(TIMER_W)) u_blink (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .load_i    (blink_load),
      .value_i   (TIMER_W'(BLINK_TICKS)),
      .tick_i    (tick_i),
      .expired_o (blink_exp)
   );

   // blink phase: 0 shows WIN_MSG, restarts at 0 on WIN entry
   always_comb begin
      blink_d = blink_q;
      if (entering && (state_d == WIN)) begin
         blink_d = 1'b0;
      end else if ((state_q == WIN) && blink_exp) begin
         blink_d = ~blink_q;
      end else begin
         blink_d = blink_q;
      end
   end

   // blink phase register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) blink_q <= 1'b0;
      else         blink_q <= blink_d;
   end

   assign win_msg = blink_q ? EMPTY_MSG : WIN_MSG;
`else
   // BLINK_TICKS has no function in the steady-message build
   logic unused_blink;
   assign unused_blink = ^TIMER_W'(BLINK_TICKS);
   assign win_msg      = WIN_MSG;
`endif

   // next state; button events take precedence over timer expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         WELCOME: if (start_i) state_d = READY; else state_d = WELCOME;
         READY: begin
            if (stop_i)       state_d = FOUL;
            else if (tmr_exp) state_d = RUN;
            else              state_d = READY;
         end
         RUN: begin
            if (sw_ovf_i)    state_d = LOSE;
            else if (stop_i) state_d = CHECK;
            else             state_d = RUN;
         end
         CHECK: state_d = (sw_frac_i == 7'd0) ? WIN : LOSE;
         WIN, LOSE: begin
            if (start_i)      state_d = READY;
            else if (tmr_exp) state_d = WELCOME;
            else              state_d = state_q;
         end
         FOUL: if (tmr_exp) state_d = WELCOME; else state_d = FOUL;
         default: state_d = WELCOME;
      endcase
   end

   // timer length for the state being entered
   always_comb begin
      tmr_value = '0;
      case (state_d)
         READY:           tmr_value = TIMER_W'(READY_TICKS);
         WIN, LOSE, FOUL: tmr_value = TIMER_W'(RESULT_TICKS);
         default:         tmr_value = '0;
      endcase
   end

   // registered outputs; CHECK holds the previous message
   always_comb begin
      msg_d   = msg_q;
      run_d   = 1'b0;
      case (state_q)
         WELCOME: msg_d = WELCOME_MSG;
         READY:   msg_d = READY_MSG;
         RUN: begin
            msg_d = STOPWATCH_MSG;
            run_d = 1'b1;
         end
         CHECK:   msg_d = msg_q;
         WIN:     msg_d = win_msg;
         LOSE:    msg_d = STOPWATCH_MSG;
         FOUL:    msg_d = EMPTY_MSG;
         default: msg_d = EMPTY_MSG;
      endcase
      clear_d = entering && (state_d == READY);
      win_d   = entering && (state_d == WIN);
      count_d = win_d ? sat_inc8(count_q) : count_q;
   end

   // state and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= WELCOME;
         msg_q   <= EMPTY_MSG;
         run_q   <= 1'b0;
         clear_q <= 1'b0;
         win_q   <= 1'b0;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         run_q   <= run_d;
         clear_q <= clear_d;
         win_q   <= win_d;
         count_q <= count_d;
      end
   end

   assign msg_o       = msg_q;
   assign sw_run_o    = run_q;
   assign sw_clear_o  = clear_q;
   assign win_o       = win_q;
   assign win_count_o = count_q;

endmodule

// File: tb/tb_game_ctrl.sv
`timescale 1ns/1ps
module tb_game_ctrl;
   import game_ctrl_pkg::*;

   logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0, stop = 1'b0, ovf = 1'b0;
   logic [6:0] frac = 7'd0;
   msg_t       msg;
   logic       run, clr, win;
   logic [7:0] cnt;
   int         tests = 0, fails = 0, exp_cnt = 0;

   always #5 clk = ~clk;

   game_ctrl #(.READY_TICKS(3), .RESULT_TICKS(4), .BLINK_TICKS(2), .TIMER_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_i(start), .stop_i(stop),
      .sw_frac_i(frac), .sw_ovf_i(ovf), .msg_o(msg), .sw_run_o(run), .sw_clear_o(clr),
      .win_o(win), .win_count_o(cnt)
   );

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin tick = 1'b1; step(); tick = 1'b0; end
   endtask

   // from WELCOME/WIN/LOSE into RUN with the stopwatch enabled
   task automatic go_run();
      start = 1'b1; step(); start = 1'b0;
      tick_n(3); step();
   endtask

   // one complete winning round (ends in WIN, win pulse visible)
   task automatic do_win();
      go_run();
      frac = 7'd0; stop = 1'b1; step(); stop = 1'b0; step();
   endtask

   task automatic test_reset();
      step();
      tests++; if (msg !== EMPTY_MSG) begin fails++; $display("FAIL rst_msg got=%0d want=%0d", msg, EMPTY_MSG); end
      tests++; if ({run, clr, win} !== 3'b000) begin fails++; $display("FAIL rst_ctl got=%b want=000", {run, clr, win}); end
      tests++; if (cnt !== 8'd0) begin fails++; $display("FAIL rst_cnt got=%0d want=0", cnt); end
      rst_n = 1'b1; step();
      tests++; if (msg !== WELCOME_MSG) begin fails++; $display("FAIL welcome_msg got=%0d want=%0d", msg, WELCOME_MSG); end
      tests++; if ({run, clr, win} !== 3'b000) begin fails++; $display("FAIL welcome_ctl got=%b want=000", {run, clr, win}); end
      stop = 1'b1; step(); stop = 1'b0; step();
      tests++; if (msg !== WELCOME_MSG) begin fails++; $display("FAIL welcome_stop got=%0d want=%0d", msg, WELCOME_MSG); end
   endtask

   task automatic test_ready();
      start = 1'b1; step(); start = 1'b0;
      tests++; if (clr !== 1'b1) begin fails++; $display("FAIL ready_clr got=%b want=1", clr); end
      step();
      tests++; if (clr !== 1'b0) begin fails++; $display("FAIL ready_clr_end got=%b want=0", clr); end
      tests++; if (msg !== READY_MSG) begin fails++; $display("FAIL ready_msg got=%0d want=%0d", msg, READY_MSG); end
      tick_n(2); step();
      tests++; if (msg !== READY_MSG || run !== 1'b0) begin fails++; $display("FAIL ready_2tick got=%0d/%b want=%0d/0", msg, run, READY_MSG); end
      tick_n(1);
      tests++; if (run !== 1'b0) begin fails++; $display("FAIL ready_3tick_run got=%b want=0", run); end
      step();
      tests++; if (msg !== STOPWATCH_MSG || run !== 1'b1) begin fails++; $display("FAIL run_entry got=%0d/%b want=%0d/1", msg, run, STOPWATCH_MSG); end
   endtask

   task automatic test_win();
      msg_t seq [4];
`ifdef GAME_CTRL_BLINK_EN
      seq = '{WIN_MSG, EMPTY_MSG, EMPTY_MSG, WELCOME_MSG};
`else
      seq = '{WIN_MSG, WIN_MSG, WIN_MSG, WELCOME_MSG};
`endif
      frac = 7'd0; stop = 1'b1; step(); stop = 1'b0; step();
      exp_cnt = 1;
      tests++; if (run !== 1'b0 || win !== 1'b1) begin fails++; $display("FAIL win_pulse run/win got=%b/%b want=0/1", run, win); end
      tests++; if (cnt !== 8'(exp_cnt)) begin fails++; $display("FAIL win_cnt got=%0d want=%0d", cnt, exp_cnt); end
      tests++; if (msg !== STOPWATCH_MSG) begin fails++; $display("FAIL check_msg got=%0d want=%0d", msg, STOPWATCH_MSG); end
      step();
      tests++; if (msg !== WIN_MSG || win !== 1'b0) begin fails++; $display("FAIL win_msg got=%0d/%b want=%0d/0", msg, win, WIN_MSG); end
      for (int i = 0; i < 4; i++) begin
         tick_n(1); step();
         tests++; if (msg !== seq[i]) begin fails++; $display("FAIL win_tick%0d got=%0d want=%0d", i + 1, msg, seq[i]); end
      end
   endtask

   task automatic test_lose();
      go_run();
      frac = 7'd37; stop = 1'b1; step(); stop = 1'b0; step();
      tests++; if (win !== 1'b0 || run !== 1'b0) begin fails++; $display("FAIL lose_ctl win/run got=%b/%b want=0/0", win, run); end
      step();
      tests++; if (msg !== STOPWATCH_MSG || cnt !== 8'(exp_cnt)) begin fails++; $display("FAIL lose_msg got=%0d/%0d want=%0d/%0d", msg, cnt, STOPWATCH_MSG, exp_cnt); end
      start = 1'b1; step(); start = 1'b0;
      tests++; if (clr !== 1'b1) begin fails++; $display("FAIL lose_restart_clr got=%b want=1", clr); end
      step();
      tests++; if (msg !== READY_MSG) begin fails++; $display("FAIL lose_restart_msg got=%0d want=%0d", msg, READY_MSG); end
   endtask

   task automatic test_foul();
      stop = 1'b1; step(); stop = 1'b0; step();
      tests++; if (msg !== EMPTY_MSG) begin fails++; $display("FAIL foul_msg got=%0d want=%0d", msg, EMPTY_MSG); end
      start = 1'b1; step(); start = 1'b0;
      tests++; if (clr !== 1'b0) begin fails++; $display("FAIL foul_start_clr got=%b want=0", clr); end
      tick_n(3); step();
      tests++; if (msg !== EMPTY_MSG) begin fails++; $display("FAIL foul_3tick got=%0d want=%0d", msg, EMPTY_MSG); end
      tick_n(1); step();
      tests++; if (msg !== WELCOME_MSG) begin fails++; $display("FAIL foul_exit got=%0d want=%0d", msg, WELCOME_MSG); end
   endtask

   task automatic test_priority();
      start = 1'b1; step(); start = 1'b0;
      tick_n(2);
      tick = 1'b1; stop = 1'b1; step(); tick = 1'b0; stop = 1'b0; step(); step();
      tests++; if (msg !== EMPTY_MSG || run !== 1'b0) begin fails++; $display("FAIL prio_stop_vs_exp got=%0d/%b want=%0d/0", msg, run, EMPTY_MSG); end
      tick_n(4); step();
      go_run();
      frac = 7'd0; ovf = 1'b1; stop = 1'b1; step(); ovf = 1'b0; stop = 1'b0; step();
      tests++; if (win !== 1'b0) begin fails++; $display("FAIL prio_ovf_win got=%b want=0", win); end
      step();
      tests++; if (msg !== STOPWATCH_MSG || cnt !== 8'(exp_cnt) || run !== 1'b0) begin fails++; $display("FAIL prio_ovf_lose got=%0d/%0d/%b want=%0d/%0d/0", msg, cnt, run, STOPWATCH_MSG, exp_cnt); end
      tick_n(3);
      tick = 1'b1; start = 1'b1; step(); tick = 1'b0; start = 1'b0;
      tests++; if (clr !== 1'b1) begin fails++; $display("FAIL prio_start_vs_exp got=%b want=1", clr); end
      stop = 1'b1; step(); stop = 1'b0;
      tick_n(4); step();
      tests++; if (msg !== WELCOME_MSG) begin fails++; $display("FAIL prio_back_welcome got=%0d want=%0d", msg, WELCOME_MSG); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300 && exp_cnt < 255; i++) begin
         do_win();
         exp_cnt++;
      end
      tests++; if (cnt !== 8'd255) begin fails++; $display("FAIL sat_reach got=%0d want=255", cnt); end
      do_win();
      tests++; if (cnt !== 8'd255 || win !== 1'b1) begin fails++; $display("FAIL sat_hold cnt/win got=%0d/%b want=255/1", cnt, win); end
   endtask

   task automatic test_reset_mid_run();
      go_run();
      tests++; if (run !== 1'b1) begin fails++; $display("FAIL midrun_pre got=%b want=1", run); end
      rst_n = 1'b0; #1;
      tests++; if (run !== 1'b0 || win !== 1'b0 || cnt !== 8'd0 || msg !== EMPTY_MSG) begin fails++; $display("FAIL midrun_rst got=%b/%b/%0d/%0d want=0/0/0/%0d", run, win, cnt, msg, EMPTY_MSG); end
      #2; rst_n = 1'b1; step(); step();
      tests++; if (msg !== WELCOME_MSG || run !== 1'b0) begin fails++; $display("FAIL midrun_after got=%0d/%b want=%0d/0", msg, run, WELCOME_MSG); end
   endtask

   initial begin
      test_reset();
      test_ready();
      test_win();
      test_lose();
      test_foul();
      test_priority();
      test_saturate();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
